fns_cac_encoder_seq: RTL

- Parametrised, iterative Fibonacci-numeral-system (FNS) crosstalk-avoidance encoder.
- Maps a DW-bit binary word to a CW-bit forbidden-transition-free codeword, resolving one code bit per cycle from MSB to LSB.
- Sits between the data source and the bus-link driver, with valid/ready handshakes on both sides.
- Successor to the fixed 7-bit combinational encoder: widths are generic, it has flow control, and it detects out-of-range input.

---
 rtl/fns_cac_pkg.sv | 29 ++
 rtl/fns_cac_encoder_seq_bit_step.sv | 26 ++
 rtl/fns_cac_encoder_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fns_cac_pkg.sv
// Shared definitions for the Fibonacci-numeral-system crosstalk-avoidance encoders.
// Weight W[k] = F(k+1); legal input range for a CW-bit code is 0..F(CW+2)-1.
package fns_cac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    DONE
  } fns_state_t;

  function automatic int unsigned fns_weight(input int unsigned k);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 1;
    for (int unsigned i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int unsigned fns_range(input int unsigned cw);
    return fns_weight(cw + 1);
  endfunction

endpackage

// File: rtl/fns_cac_encoder_seq_bit_step.sv
// One FNS resolution step: decides code bit k from remainder r and weights W[k], W[k+1].
// Combinational, zero latency, no flow control.
module fns_bit_step #(
  parameter int DW = 6
) (
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] w_k,
  input  logic [DW-1:0] w_k1,
  input  logic          bit_above,
  output logic          code_bit,
  output logic [DW-1:0] r_next
);

  // In the ambiguous band W[k] <= r < W[k+1] copying the bit above keeps the code FT-free.
  always_comb begin
    if (r >= w_k1) begin
      code_bit = 1'b1;
    end else if (r < w_k) begin
      code_bit = 1'b0;
    end else begin
      code_bit = bit_above;
    end
    r_next = code_bit ? (r - w_k) : r;
  end

endmodule

// File: rtl/fns_cac_encoder_seq.sv
// Iterative FNS crosstalk-avoidance encoder, one code bit per cycle MSB first.
// Latency CW+1 cycles (1 for out-of-range input); holds output until out_ready, no overlap.
module fns_cac_encoder_seq
  import fns_cac_pkg::*;
#(
  parameter int CW = 7,
  parameter int DW = 6
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_code,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int          KW    = $clog2(CW + 1);
  localparam int unsigned RANGE = fns_range(CW);
  localparam logic [DW:0] RANGE_W = (DW + 1)'(RANGE);

  generate
    if ((CW < 3) || (CW > 24) || (DW > 31) || ((32'd1 << DW) < RANGE)) begin : g_bad_params
      $error("fns_cac_encoder_seq: CW must be 3..24 and 2**DW must be >= F(CW+2)");
    end
  endgenerate

  function automatic logic [CW:0][DW-1:0] build_wtab();
    logic [CW:0][DW-1:0] t;
    for (int i = 0; i <= CW; i++) begin
      t[i] = DW'(fns_weight(i));
    end
    return t;
  endfunction

  localparam logic [CW:0][DW-1:0] WTAB = build_wtab();

  fns_state_t    state_q, state_d;
  logic [DW-1:0] r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] code_q, code_d;
  logic          err_q, err_d;
  logic          prev_q, prev_d;

  logic [KW-1:0] k_p1;
  logic          step_bit;
  logic [DW-1:0] step_r;

  assign k_p1 = k_q + KW'(1);

  fns_bit_step #(.DW(DW)) u_step (
    .r         (r_q),
    .w_k       (WTAB[k_q]),
    .w_k1      (WTAB[k_p1]),
    .bit_above (prev_q),
    .code_bit  (step_bit),
    .r_next    (step_r)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      k_q     <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      code_q  <= code_d;
      err_q   <= err_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    code_d    = code_q;
    err_d     = err_q;
    prev_d    = prev_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d    = in_data;
          k_d    = KW'(CW - 1);
          code_d = '0;
          prev_d = 1'b0;
          if ({1'b0, in_data} >= RANGE_W) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ENC;
          end
        end
      end
      ENC: begin
        r_d    = step_r;
        prev_d = step_bit;
        code_d = code_q | (CW'(step_bit) << k_q);
        if (k_q == '0) begin
          state_d = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_code = code_q;
  assign out_err  = err_q;

endmodule
